// File: rtl/parts_pkg.sv
// Shared type definitions for the internal-bus control blocks.
package parts_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from
// ptr+1, wrapping modulo NREQ, so the last owner is considered last.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[IW'((int'(ptr) + i) % NREQ)]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner sequencer for the shared tristate bus: one-hot grants,
// a dead TURN cycle between owners, and a bounded hold per ownership.
module bus_arbiter_rr
    import parts_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IW       = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] drive_en,
    output logic [IW-1:0]   owner,
    output logic            bus_busy,
    output logic            timeout
);

    localparam int            HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            timeout_q, timeout_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            owner_done, owner_req, hold_limit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_done = done[owner_q];
    assign owner_req  = req[owner_q];
    assign hold_limit = (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ARB_IDLE, ARB_TURN: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
                if (pick_found) begin
                    state_d           = ARB_GRANT;
                    owner_d           = pick_idx;
                    gnt_d[pick_idx]   = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (owner_done || !owner_req || hold_limit) begin
                    state_d    = ARB_TURN;
                    ptr_d      = owner_q;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d  = hold_limit && !owner_done && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IW'(NREQ - 1);
            owner_q    <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt      = gnt_q;
    assign drive_en = (state_q == ARB_GRANT) ? gnt_q : '0;
    assign owner    = owner_q;
    assign bus_busy = (state_q == ARB_GRANT);
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr (NREQ=4, MAX_HOLD=4): directed scenarios
// plus a long random run checking one-hot and turnaround invariants.
module tb_bus_arbiter_rr;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [3:0] drive_en;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_arbiter_rr #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .drive_en (drive_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Queue the expectation for the coming edge, apply inputs, then step past it.
    task automatic drive_expect(input logic [3:0] r, input logic [3:0] d,
                                input logic [3:0] g, input logic t);
        exp_t x;
        x.gnt = g;
        x.tmo = t;
        exp_q.push_back(x);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        done  = 4'b0000;
        @(posedge clk);
        #1;
        n_checks++;
        if ({gnt, drive_en, bus_busy, timeout} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b drive_en=%b busy=%b timeout=%b, expected all zero",
                     gnt, drive_en, bus_busy, timeout);
        end
        n_checks++;
        if (owner !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_owner: got %0d, expected 0", owner);
        end
        reset = 1'b0;
        drive_expect(4'b1111, 4'b0000, 4'b0001, 1'b0);
        begin
            exp_t e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL reset_first_pick: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
        end
    endtask

    task automatic test_single_grant();
        logic [3:0] r_t [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] d_t [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] g_t [4] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_expect(r_t[i], d_t[i], g_t[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
            if (i == 0) begin
                n_checks++;
                if (owner !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_grant_owner: got %0d, expected 2", owner);
                end
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0)
                drive_expect(4'b1111, 4'b0000, 4'(1) << ((k / 2) % NREQ), 1'b0);
            else
                drive_expect(4'b1111, 4'b1111, 4'b0000, 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         k, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
        end
    endtask

    task automatic test_hold_timeout();
        logic [3:0] g_t [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        logic       t_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_expect(4'b0001, 4'b0000, g_t[i], t_t[i]);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL hold_timeout[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
        end
    endtask

    task automatic test_done_filter();
        logic [3:0] r_t [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        logic [3:0] d_t [6] = '{4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b0010, 4'b0000};
        logic [3:0] g_t [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        exp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_expect(r_t[i], d_t[i], g_t[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL done_filter[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] r_t [3] = '{4'b0100, 4'b0000, 4'b0000};
        logic [3:0] g_t [3] = '{4'b0100, 4'b0000, 4'b0000};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_expect(r_t[i], 4'b0000, g_t[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL withdraw[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] r_t [3] = '{4'b1000, 4'b1000, 4'b1111};
        logic       s_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] g_t [3] = '{4'b1000, 4'b0000, 4'b0001};
        exp_t e;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            reset = s_t[i];
            drive_expect(r_t[i], 4'b0000, g_t[i], 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if ({gnt, drive_en, bus_busy, timeout} !== {e.gnt, e.gnt, |e.gnt, e.tmo}) begin
                n_fail++;
                $display("FAIL reset_mid_grant[%0d]: got gnt=%b drive_en=%b busy=%b timeout=%b, expected gnt=%b timeout=%b",
                         i, gnt, drive_en, bus_busy, timeout, e.gnt, e.tmo);
            end
            if (i == 0) begin
                n_checks++;
                if (owner !== 2'd3) begin
                    n_fail++;
                    $display("FAIL reset_mid_grant_owner: got %0d, expected 3", owner);
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] prev_de = '0;
        int         run     = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            req  = 4'($urandom_range(0, 15));
            done = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            n_checks++;
            if ($countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL random_onehot[%0d]: got gnt=%b, expected at most one bit", c, gnt);
            end
            n_checks++;
            if (prev_de != 4'b0 && drive_en != 4'b0 && drive_en != prev_de) begin
                n_fail++;
                $display("FAIL random_turnaround[%0d]: got drive_en=%b after %b, expected a dead cycle", c, drive_en, prev_de);
            end
            run = (drive_en != 4'b0) ? ((drive_en == prev_de) ? run + 1 : 1) : 0;
            n_checks++;
            if (run > MAX_HOLD) begin
                n_fail++;
                $display("FAIL random_hold[%0d]: got %0d consecutive owned cycles, expected <= %0d", c, run, MAX_HOLD);
            end
            n_checks++;
            if (timeout && (prev_de == 4'b0 || drive_en != 4'b0)) begin
                n_fail++;
                $display("FAIL random_timeout[%0d]: got timeout=1 with prev drive_en=%b drive_en=%b, expected only right after an ownership",
                         c, prev_de, drive_en);
            end
            prev_de = drive_en;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = '0;
        test_reset();
        test_single_grant();
        test_rotation();
        test_hold_timeout();
        test_done_filter();
        test_withdraw();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
